// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the parametrised 1RW SRAM model.
//   sram_state_e   : clear sequencer states (CLEAR walks the array, IDLE serves accesses)
//   MASK_GRAN_DEF  : default bits per write-mask lane
//   bweb_to_mask() : expands an active-low per-lane write enable into an
//                    active-high per-bit write mask (MASK_MAX_W bits wide,
//                    callers slice off the low WIDTH bits)
package sram_pkg;

    localparam int MASK_GRAN_DEF = 8;
    localparam int MASK_MAX_W    = 1024;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } sram_state_e;

    // Bits beyond nb*gran stay 0 so padding lanes can never enable a write.
    function automatic logic [MASK_MAX_W-1:0] bweb_to_mask(
        input logic [MASK_MAX_W-1:0] bweb,
        input int                    nb,
        input int                    gran
    );
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX_W; i++) begin
            if (i < nb * gran) m[i] = ~bweb[i / gran];
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_clear_ctrl.sv
// sram_clear_ctrl: clear sequencer for sram_1rw_param.
//   gclk     in  : clock
//   grst_n   in  : async active-low reset, forces CLEAR at address 0
//   clrb     in  : clear request (active low), only honoured in IDLE
//   rdy      out : high in IDLE (array cleared, accesses accepted)
//   clr_we   out : clear write strobe, one zero word per cycle in CLEAR
//   clr_addr out : address of the word being cleared
module sram_clear_ctrl
    import sram_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          gclk,
    input  logic          grst_n,
    input  logic          clrb,
    output logic          rdy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    sram_state_e   state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                // Last word written on this edge: RDY becomes visible next cycle.
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            IDLE: begin
                if (!clrb) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign rdy      = (state_q == IDLE);
    assign clr_addr = clr_addr_q;

endmodule

// File: rtl/sram_1rw_param.sv
// sram_1rw_param: parametrised single-port SRAM model with per-lane write
// mask, read-before-write on simultaneous access and a hardware clear pass.
//   CE      in  : clock (rising edge)
//   RSTB    in  : async active-low reset
//   CSB/WEB/OEB in : chip select / write enable / read enable, active low
//   CLRB    in  : clear request, active low, sampled in IDLE
//   A       in  : word address (A >= DEPTH: write dropped, read returns 0)
//   I       in  : write data
//   BWEB    in  : per-lane write enable, active low
//   O       out : read data, held between reads
//   RVALID  out : one-cycle pulse with fresh read data
//   RDY     out : array cleared, accesses accepted
// Optional build macro SRAM_OUT_REG_EN adds an output register stage
// (read latency 2); the stage drops its valid when a clear pass starts.
module sram_1rw_param
    import sram_pkg::*;
#(
    parameter  int WIDTH     = 64,
    parameter  int DEPTH     = 128,
    parameter  int MASK_GRAN = MASK_GRAN_DEF,
    localparam int AW        = $clog2(DEPTH),
    localparam int NB        = WIDTH / MASK_GRAN
) (
    input  logic             CE,
    input  logic             RSTB,
    input  logic             CSB,
    input  logic             WEB,
    input  logic             OEB,
    input  logic             CLRB,
    input  logic [AW-1:0]    A,
    input  logic [WIDTH-1:0] I,
    input  logic [NB-1:0]    BWEB,
    output logic [WIDTH-1:0] O,
    output logic             RVALID,
    output logic             RDY
);

    logic                  rdy, clr_we;
    logic [AW-1:0]         clr_addr;
    logic                  re, we, in_range;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [MASK_MAX_W-1:0] mask_full;
    logic [WIDTH-1:0]      wmask, rd_word;
    logic [WIDTH-1:0]      o_q, o_d;
    logic                  rvalid_q, rvalid_d;
    logic                  unused_mask_hi;

    sram_clear_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_clr (
        .gclk     (CE),
        .grst_n   (RSTB),
        .clrb     (CLRB),
        .rdy      (rdy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign re  = ~CSB & ~OEB & rdy;
    assign we  = ~CSB & ~WEB & rdy;
    assign RDY = rdy;

    // A power-of-two depth has no unreachable addresses.
    if (DEPTH == (1 << AW)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = (int'(A) < DEPTH);
    end

    assign mask_full      = bweb_to_mask({{(MASK_MAX_W-NB){1'b1}}, BWEB}, NB, MASK_GRAN);
    assign wmask          = mask_full[WIDTH-1:0];
    assign unused_mask_hi = |mask_full[MASK_MAX_W-1:WIDTH];

    assign rd_word = in_range ? mem[A] : '0;

    // Array has no reset; the clear pass zeroes it. Clear and user writes are
    // exclusive since user writes need RDY.
    always_ff @(posedge CE) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (we && in_range) begin
            mem[A] <= (mem[A] & ~wmask) | (I & wmask);
        end
    end

    // Read samples the pre-write word, giving read-before-write on RE&WE.
    always_comb begin
        o_d      = o_q;
        rvalid_d = re;
        if (re) o_d = rd_word;
    end

    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            o_q      <= '0;
            rvalid_q <= 1'b0;
        end else begin
            o_q      <= o_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic [WIDTH-1:0] o_p_q, o_p_d;
    logic             rvalid_p_q, rvalid_p_d;
    logic             clr_start;

    // IDLE->CLEAR transition edge.
    assign clr_start = rdy & ~CLRB;

    always_comb begin
        o_p_d      = o_q;
        rvalid_p_d = rvalid_q & ~clr_start;
    end

    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            o_p_q      <= '0;
            rvalid_p_q <= 1'b0;
        end else begin
            o_p_q      <= o_p_d;
            rvalid_p_q <= rvalid_p_d;
        end
    end

    assign O      = o_p_q;
    assign RVALID = rvalid_p_q;
`else
    assign O      = o_q;
    assign RVALID = rvalid_q;
`endif

endmodule

// File: tb/tb_sram_1rw_param.sv
module tb_sram_1rw_param;

`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CE = 1'b0, RSTB = 1'b1;
    logic        CSB = 1'b1, WEB = 1'b1, OEB = 1'b1, CLRB = 1'b1;
    logic [6:0]  A = '0;
    logic [63:0] I = '0;
    logic [7:0]  BWEB = '1;
    logic [63:0] O0, O1;
    logic        RV0, RV1, RDY0, RDY1;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    always #5 CE = ~CE;

    sram_1rw_param #(.WIDTH(64), .DEPTH(128), .MASK_GRAN(8)) u_dut0 (
        .CE(CE), .RSTB(RSTB), .CSB(CSB), .WEB(WEB), .OEB(OEB), .CLRB(CLRB),
        .A(A), .I(I), .BWEB(BWEB), .O(O0), .RVALID(RV0), .RDY(RDY0));

    sram_1rw_param #(.WIDTH(64), .DEPTH(100), .MASK_GRAN(8)) u_dut1 (
        .CE(CE), .RSTB(RSTB), .CSB(CSB), .WEB(WEB), .OEB(OEB), .CLRB(CLRB),
        .A(A), .I(I), .BWEB(BWEB), .O(O1), .RVALID(RV1), .RDY(RDY1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (both depths) ----------------
    int        dep [2] = '{128, 100};
    bit [63:0] mm [2][128];
    bit        m_rdy [2];
    int        m_left [2];       // clear writes still to do
    bit [63:0] m_o [2][LAT];     // output history: index 0 newest read result
    bit        m_v [2][LAT];

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_rdy[d]  = 1'b0;
            m_left[d] = dep[d];
            for (int s = 0; s < LAT; s++) begin
                m_o[d][s] = '0;
                m_v[d][s] = 1'b0;
            end
        end
    endtask

    always @(negedge RSTB) m_reset();

    always @(posedge CE) begin
        if (!RSTB) begin
            m_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit re, we, enter_clr;
                re        = !CSB && !OEB && m_rdy[d];
                we        = !CSB && !WEB && m_rdy[d];
                enter_clr = m_rdy[d] && !CLRB;
                // age the history; a clear start drops any read still in flight
                for (int s = LAT - 1; s > 0; s--) begin
                    m_o[d][s] = m_o[d][s-1];
                    m_v[d][s] = m_v[d][s-1] && !enter_clr;
                end
                m_v[d][0] = re;
                if (re) m_o[d][0] = (int'(A) < dep[d]) ? mm[d][A] : 64'd0;
                if (we && int'(A) < dep[d])
                    for (int k = 0; k < 8; k++)
                        if (!BWEB[k]) mm[d][A][k*8 +: 8] = I[k*8 +: 8];
                if (!m_rdy[d]) begin
                    mm[d][dep[d] - m_left[d]] = '0;
                    m_left[d]--;
                    if (m_left[d] == 0) m_rdy[d] = 1'b1;
                end else if (!CLRB) begin
                    m_rdy[d]  = 1'b0;
                    m_left[d] = dep[d];
                end
            end
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge CE) begin
        if (chk_en) begin
            chk("o_d128",      O0,   m_o[0][LAT-1]);
            chk("rvalid_d128", RV0,  m_v[0][LAT-1]);
            chk("rdy_d128",    RDY0, m_rdy[0]);
            chk("o_d100",      O1,   m_o[1][LAT-1]);
            chk("rvalid_d100", RV1,  m_v[1][LAT-1]);
            chk("rdy_d100",    RDY1, m_rdy[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic csb, input logic web, input logic oeb, input logic clrb,
                         input logic [6:0] a, input logic [63:0] i, input logic [7:0] bweb);
        #1;
        CSB = csb; WEB = web; OEB = oeb; CLRB = clrb; A = a; I = i; BWEB = bweb;
    endtask

    task automatic drive_idle();
        drive(1'b1, 1'b1, 1'b1, 1'b1, '0, '0, '1);
    endtask

    task automatic wr(input logic [6:0] a, input logic [63:0] i, input logic [7:0] bweb);
        drive(1'b0, 1'b0, 1'b1, 1'b1, a, i, bweb);
        @(negedge CE);
        drive_idle();
    endtask

    task automatic rd_check(input logic [6:0] a, input logic [63:0] exp, input string name);
        drive(1'b0, 1'b1, 1'b0, 1'b1, a, '0, '1);
        @(negedge CE);
        drive_idle();
        repeat (LAT - 1) @(negedge CE);
        chk({name, "_o"}, O0, exp);
        chk({name, "_rvalid"}, RV0, 64'd1);
        @(negedge CE);
        chk({name, "_rvalid_off"}, RV0, 64'd0);
    endtask

    task automatic wait_rdy(input string name);
        int edges, e100;
        edges = 0;
        e100  = 0;
        while (!RDY0 && edges < 400) begin
            @(negedge CE);
            edges++;
            if (RDY1 && e100 == 0) e100 = edges;
        end
        chk({name, "_edges_d128"}, 64'(edges), 64'd128);
        chk({name, "_edges_d100"}, 64'(e100), 64'd100);
    endtask

    initial begin
        logic [63:0] x, y;
        int          low;
        x = 64'h0123_4567_89AB_CDEF;
        y = 64'hFEDC_BA98_7654_3210;

        #1 RSTB = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge CE);
        chk("reset_o", O0, 64'd0);
        chk("reset_rvalid", RV0, 64'd0);
        chk("reset_rdy", RDY0, 64'd0);
        #1 RSTB = 1'b1;
        wait_rdy("post_reset");

        rd_check(7'd7, 64'd0, "rd7_cleared");
        wr(7'd5, x, 8'h00);
        rd_check(7'd5, x, "rd5_full");
        wr(7'd3, '1, 8'hF0);
        rd_check(7'd3, 64'h0000_0000_FFFF_FFFF, "rd3_mask");

        // read-during-write: old data comes out, new data lands
        drive(1'b0, 1'b0, 1'b0, 1'b1, 7'd5, y, 8'h00);
        @(negedge CE);
        drive_idle();
        repeat (LAT - 1) @(negedge CE);
        chk("rdw_old_o", O0, x);
        chk("rdw_rvalid", RV0, 64'd1);
        @(negedge CE);
        rd_check(7'd5, y, "rdw_new");

        // address beyond depth on the 100-deep instance
        wr(7'd110, 64'hDEAD_BEEF_0000_1111, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 7'd110, '0, '1);
        @(negedge CE);
        drive_idle();
        repeat (LAT - 1) @(negedge CE);
        chk("oor_d100_o", O1, 64'd0);
        chk("oor_d100_rvalid", RV1, 64'd1);
        chk("oor_d128_o", O0, 64'hDEAD_BEEF_0000_1111);
        @(negedge CE);

        // clear request, with a write attempted mid-clear
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '1);
        @(negedge CE);
        drive_idle();
        low = 0;
        while (!RDY0 && low < 400) begin
            low++;
            if (low == 5) drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd5, '1, 8'h00);
            else if (low == 6) drive_idle();
            @(negedge CE);
        end
        chk("clr_low_cycles", 64'(low), 64'd128);
        rd_check(7'd5, 64'd0, "rd5_after_clr");

        // reset while clr_addr is around 60
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '1);
        @(negedge CE);
        drive_idle();
        repeat (60) @(negedge CE);
        #1 RSTB = 1'b0;
        @(negedge CE);
        chk("midclr_rst_rdy", RDY0, 64'd0);
        chk("midclr_rst_o", O0, 64'd0);
        #1 RSTB = 1'b1;
        wait_rdy("midclr_reset");

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15)),
                  {$urandom, $urandom}, 8'($urandom));
            RSTB = ($urandom_range(0, 1499) != 0);
            @(negedge CE);
        end
        drive_idle();
        RSTB = 1'b1;
        @(negedge CE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
